// File: rtl/turn_signal_pkg.sv
// Shared types and helpers for the sequential turn-signal controller.
// Latency: none (types and pure functions only).
// Backpressure: none.
package turn_signal_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LEFT   = 2'd1,
        RIGHT  = 2'd2,
        HAZARD = 2'd3
    } mode_t;

    // Widest lamp bank the thermometer helper can encode; callers cast down to LAMPS.
    localparam int unsigned THERM_MAX = 32;

    // Thermometer code: the lowest n bits set, the rest clear.
    function automatic logic [THERM_MAX-1:0] therm_encode(input int unsigned n);
        logic [THERM_MAX-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < THERM_MAX; i++) begin
            if (i < n) begin
                v[i] = 1'b1;
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/turn_tick_prescaler.sv
// Free-running step prescaler: tick pulses once every TICK_DIV clocks.
// Latency: tick is a decode of the registered count; first tick on the TICK_DIV-th edge after reset.
// Backpressure: none; runs unconditionally from reset.
module turn_tick_prescaler #(
    parameter int TICK_DIV = 1
) (
    input  logic Clk,
    input  logic Rst_n,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] count;

    // With TICK_DIV=1 the count is pinned at 0 == CNT_LAST, so tick stays high.
    assign tick = (count == CNT_LAST);

    // Count 0..TICK_DIV-1 and wrap.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            count <= '0;
        end else if (count == CNT_LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/turn_signal_seq.sv
// Sequential turn-signal controller: LAMPS lamps per side from E/L/R requests (optional Brake overlay via TURN_BRAKE_EN).
// Latency: mode/step change within TICK_DIV clocks; all outputs registered; brake overlay 1 clock.
// Backpressure: none; requests are level-sampled on tick cycles only.
module turn_signal_seq
    import turn_signal_pkg::*;
#(
    parameter int LAMPS    = 3,
    parameter int TICK_DIV = 1
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             E,
    input  logic             L,
    input  logic             R,
`ifdef TURN_BRAKE_EN
    input  logic             Brake,
`endif
    output logic [LAMPS-1:0] LeftLamps,
    output logic [LAMPS-1:0] RightLamps,
    output logic             Active
);

    localparam int STEP_W = $clog2(LAMPS + 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(LAMPS);

    mode_t             mode;
    mode_t             req_mode;
    mode_t             next_mode;
    logic [STEP_W-1:0] step;
    logic [STEP_W-1:0] next_step;
    logic              tick;
    logic [LAMPS-1:0]  seq_left;
    logic [LAMPS-1:0]  seq_right;
    logic [LAMPS-1:0]  out_left;
    logic [LAMPS-1:0]  out_right;

    turn_tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .tick  (tick)
    );

    // Request priority: hazard (or both turns) beats a single turn.
    always_comb begin
        req_mode = IDLE;
        if (E || (L && R)) begin
            req_mode = HAZARD;
        end else if (L) begin
            req_mode = LEFT;
        end else if (R) begin
            req_mode = RIGHT;
        end
    end

    // Mode/step advance on tick; any mode change restarts the pattern at step 0.
    always_comb begin
        next_mode = mode;
        next_step = step;
        if (tick) begin
            if (req_mode != mode) begin
                next_mode = req_mode;
                next_step = '0;
            end else begin
                case (mode)
                    LEFT, RIGHT: next_step = (step == STEP_LAST) ? '0 : step + 1'b1;
                    HAZARD:      next_step = {{(STEP_W-1){1'b0}}, ~step[0]};
                    default:     next_step = '0;
                endcase
            end
        end
    end

    // Sequencer pattern from the mode/step about to be registered.
    always_comb begin
        seq_left  = '0;
        seq_right = '0;
        case (next_mode)
            LEFT:    seq_left  = LAMPS'(therm_encode(32'(next_step)));
            RIGHT:   seq_right = LAMPS'(therm_encode(32'(next_step)));
            HAZARD: begin
                if (next_step[0]) begin
                    seq_left  = '1;
                    seq_right = '1;
                end
            end
            default: ;
        endcase
    end

`ifdef TURN_BRAKE_EN
    // Brake lights every side that is not sequencing; hazard pattern is left untouched.
    always_comb begin
        out_left  = seq_left;
        out_right = seq_right;
        if (Brake) begin
            case (next_mode)
                IDLE: begin
                    out_left  = '1;
                    out_right = '1;
                end
                LEFT:    out_right = '1;
                RIGHT:   out_left  = '1;
                default: ;
            endcase
        end
    end
`else
    assign out_left  = seq_left;
    assign out_right = seq_right;
`endif

    // State and output registers; updated every clock so the brake overlay is not tick-gated.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            mode       <= IDLE;
            step       <= '0;
            LeftLamps  <= '0;
            RightLamps <= '0;
            Active     <= 1'b0;
        end else begin
            mode       <= next_mode;
            step       <= next_step;
            LeftLamps  <= out_left;
            RightLamps <= out_right;
            Active     <= (next_mode != IDLE);
        end
    end

endmodule

// File: tb/tb_turn_signal_seq.sv
// Bench for turn_signal_seq: two instances (3 lamps / step every clock, 4 lamps / step every 4 clocks).
// Latency: checks one time unit after each rising edge against a sequence-position model.
// Backpressure: n/a; define TURN_BRAKE_EN to include the brake scenarios.
module tb_turn_signal_seq;

    localparam int LMP [2] = '{3, 4};
    localparam int TD  [2] = '{1, 4};

    logic Clk_tb;
    logic Rst_n;
    logic E;
    logic L;
    logic R;
`ifdef TURN_BRAKE_EN
    logic Brake;
`endif

    logic [2:0] a_left, a_right;
    logic [3:0] b_left, b_right;
    logic       a_act, b_act;

    logic [7:0] obs_l [2];
    logic [7:0] obs_r [2];
    logic       obs_a [2];

    // Model: requested mode (0 idle, 1 left, 2 right, 3 hazard), position in its cycle, clocks since reset.
    int         m_mode [2];
    int         m_pos  [2];
    int         m_cyc  [2];
    logic [7:0] exp_l  [2];
    logic [7:0] exp_r  [2];
    logic       exp_a  [2];

    int checks;
    int failures;

    turn_signal_seq #(.LAMPS(3), .TICK_DIV(1)) u_a (
        .Clk        (Clk_tb),
        .Rst_n      (Rst_n),
        .E          (E),
        .L          (L),
        .R          (R),
`ifdef TURN_BRAKE_EN
        .Brake      (Brake),
`endif
        .LeftLamps  (a_left),
        .RightLamps (a_right),
        .Active     (a_act)
    );

    turn_signal_seq #(.LAMPS(4), .TICK_DIV(4)) u_b (
        .Clk        (Clk_tb),
        .Rst_n      (Rst_n),
        .E          (E),
        .L          (L),
        .R          (R),
`ifdef TURN_BRAKE_EN
        .Brake      (Brake),
`endif
        .LeftLamps  (b_left),
        .RightLamps (b_right),
        .Active     (b_act)
    );

    assign obs_l[0] = {5'b0, a_left};
    assign obs_r[0] = {5'b0, a_right};
    assign obs_a[0] = a_act;
    assign obs_l[1] = {4'b0, b_left};
    assign obs_r[1] = {4'b0, b_right};
    assign obs_a[1] = b_act;

    initial Clk_tb = 1'b0;
    always #5 Clk_tb = ~Clk_tb;

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_mode[i] = 0;
            m_pos[i]  = 0;
            m_cyc[i]  = 0;
            exp_l[i]  = 8'h00;
            exp_r[i]  = 8'h00;
            exp_a[i]  = 1'b0;
        end
    endtask

    // Advance the model by one rising edge using the inputs present at that edge.
    task automatic model_edge();
        int req;
        int period;
        logic [7:0] full;
        logic [7:0] th;
        if (!Rst_n) begin
            model_reset();
            return;
        end
        req = E ? 3 : (L && R) ? 3 : L ? 1 : R ? 2 : 0;
        for (int i = 0; i < 2; i++) begin
            m_cyc[i]++;
            if (m_cyc[i] % TD[i] == 0) begin
                if (req != m_mode[i]) begin
                    m_mode[i] = req;
                    m_pos[i]  = 0;
                end else begin
                    period   = (m_mode[i] == 1 || m_mode[i] == 2) ? LMP[i] + 1 :
                               (m_mode[i] == 3) ? 2 : 1;
                    m_pos[i] = (m_pos[i] + 1) % period;
                end
            end
            full = 8'((1 << LMP[i]) - 1);
            th   = 8'((1 << m_pos[i]) - 1);
            exp_l[i] = 8'h00;
            exp_r[i] = 8'h00;
            case (m_mode[i])
                1: exp_l[i] = th;
                2: exp_r[i] = th;
                3: begin
                    exp_l[i] = (m_pos[i] == 1) ? full : 8'h00;
                    exp_r[i] = exp_l[i];
                end
                default: ;
            endcase
`ifdef TURN_BRAKE_EN
            if (Brake && m_mode[i] != 3) begin
                if (m_mode[i] != 1) exp_l[i] = full;
                if (m_mode[i] != 2) exp_r[i] = full;
            end
`endif
            exp_a[i] = (m_mode[i] != 0);
        end
    endtask

    task automatic clk_step();
        @(posedge Clk_tb);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        model_reset();
        #3;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({obs_l[i], obs_r[i], obs_a[i]} !== {exp_l[i], exp_r[i], exp_a[i]}) begin
                failures++;
                $display("FAIL reset_init i%0d got L=%b R=%b A=%b want L=%b R=%b A=%b",
                         i, obs_l[i], obs_r[i], obs_a[i], exp_l[i], exp_r[i], exp_a[i]);
            end
        end
        L = 1'b1;
        clk_step();
        clk_step();
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({obs_l[i], obs_r[i], obs_a[i]} !== 17'd0) begin
                failures++;
                $display("FAIL reset_held i%0d got L=%b R=%b A=%b want all zero",
                         i, obs_l[i], obs_r[i], obs_a[i]);
            end
        end
    endtask

    task automatic test_left_seq();
        int seq [10] = '{0, 1, 3, 7, 0, 1, 3, 7, 0, 1};
        L = 1'b1; R = 1'b0; E = 1'b0;
        @(negedge Clk_tb);
        Rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            clk_step();
            checks++;
            if (obs_l[0] !== 8'(seq[k]) || obs_r[0] !== 8'h00 || obs_a[0] !== 1'b1) begin
                failures++;
                $display("FAIL left_table edge%0d got L=%b R=%b A=%b want L=%b R=0 A=1",
                         k + 1, obs_l[0], obs_r[0], obs_a[0], 8'(seq[k]));
            end
            for (int i = 0; i < 2; i++) begin
                checks++;
                if ({obs_l[i], obs_r[i], obs_a[i]} !== {exp_l[i], exp_r[i], exp_a[i]}) begin
                    failures++;
                    $display("FAIL left_seq i%0d got L=%b R=%b A=%b want L=%b R=%b A=%b",
                             i, obs_l[i], obs_r[i], obs_a[i], exp_l[i], exp_r[i], exp_a[i]);
                end
            end
        end
    endtask

    task automatic test_right_slow();
        L = 1'b0; R = 1'b1; E = 1'b0;
        for (int k = 0; k < 26; k++) begin
            clk_step();
            for (int i = 0; i < 2; i++) begin
                checks++;
                if ({obs_l[i], obs_r[i], obs_a[i]} !== {exp_l[i], exp_r[i], exp_a[i]}) begin
                    failures++;
                    $display("FAIL right_slow i%0d got L=%b R=%b A=%b want L=%b R=%b A=%b",
                             i, obs_l[i], obs_r[i], obs_a[i], exp_l[i], exp_r[i], exp_a[i]);
                end
            end
        end
    endtask

    task automatic test_hazard();
        for (int k = 0; k < 20; k++) begin
            if (k < 10) begin
                L = 1'b1; R = 1'b1; E = 1'b0;
            end else begin
                L = 1'b0; R = 1'b0; E = 1'b1;
            end
            clk_step();
            for (int i = 0; i < 2; i++) begin
                checks++;
                if ({obs_l[i], obs_r[i], obs_a[i]} !== {exp_l[i], exp_r[i], exp_a[i]}) begin
                    failures++;
                    $display("FAIL hazard i%0d got L=%b R=%b A=%b want L=%b R=%b A=%b",
                             i, obs_l[i], obs_r[i], obs_a[i], exp_l[i], exp_r[i], exp_a[i]);
                end
            end
        end
    endtask

    task automatic test_hazard_interrupt();
        bit found;
        E = 1'b0; L = 1'b0; R = 1'b0;
        for (int k = 0; k < 4; k++) clk_step();
        L = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 12 && !found; k++) begin
            clk_step();
            found = (obs_l[0] == 8'h03);
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL interrupt_reach_011 got L=%b want 00000011 within 12 cycles", obs_l[0]);
        end
        for (int k = 0; k < 8; k++) begin
            E = (k == 0);
            clk_step();
            if (k == 0) begin
                checks++;
                if (obs_l[0] !== 8'h00 || obs_r[0] !== 8'h00) begin
                    failures++;
                    $display("FAIL interrupt_first_off got L=%b R=%b want 0 0", obs_l[0], obs_r[0]);
                end
            end
            for (int i = 0; i < 2; i++) begin
                checks++;
                if ({obs_l[i], obs_r[i], obs_a[i]} !== {exp_l[i], exp_r[i], exp_a[i]}) begin
                    failures++;
                    $display("FAIL interrupt i%0d got L=%b R=%b A=%b want L=%b R=%b A=%b",
                             i, obs_l[i], obs_r[i], obs_a[i], exp_l[i], exp_r[i], exp_a[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        bit found;
        E = 1'b0; R = 1'b0; L = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 12 && !found; k++) begin
            clk_step();
            found = (obs_l[0] == 8'h03);
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL reset_mid_reach_011 got L=%b want 00000011 within 12 cycles", obs_l[0]);
        end
        #2;
        Rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({obs_l[i], obs_r[i], obs_a[i]} !== 17'd0) begin
                failures++;
                $display("FAIL reset_async i%0d got L=%b R=%b A=%b want all zero",
                         i, obs_l[i], obs_r[i], obs_a[i]);
            end
        end
        clk_step();
        @(negedge Clk_tb);
        Rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            clk_step();
            if (k == 0) begin
                checks++;
                if (obs_l[0] !== 8'h00 || obs_a[0] !== 1'b1) begin
                    failures++;
                    $display("FAIL reset_restart got L=%b A=%b want 0 1", obs_l[0], obs_a[0]);
                end
            end
            for (int i = 0; i < 2; i++) begin
                checks++;
                if ({obs_l[i], obs_r[i], obs_a[i]} !== {exp_l[i], exp_r[i], exp_a[i]}) begin
                    failures++;
                    $display("FAIL reset_resume i%0d got L=%b R=%b A=%b want L=%b R=%b A=%b",
                             i, obs_l[i], obs_r[i], obs_a[i], exp_l[i], exp_r[i], exp_a[i]);
                end
            end
        end
    endtask

`ifdef TURN_BRAKE_EN
    task automatic test_brake();
        E = 1'b0; R = 1'b0; L = 1'b1; Brake = 1'b0;
        for (int k = 0; k < 5; k++) clk_step();
        for (int k = 0; k < 16; k++) begin
            Brake = 1'b1;
            E = (k >= 8);
            clk_step();
            if (k == 0) begin
                checks++;
                if (obs_r[0] !== 8'h07) begin
                    failures++;
                    $display("FAIL brake_right got R=%b want 00000111", obs_r[0]);
                end
            end
            if (k >= 9) begin
                checks++;
                if (obs_l[0] !== obs_r[0] || (obs_l[0] !== 8'h00 && obs_l[0] !== 8'h07)) begin
                    failures++;
                    $display("FAIL brake_hazard got L=%b R=%b want equal 000/111", obs_l[0], obs_r[0]);
                end
            end
            for (int i = 0; i < 2; i++) begin
                checks++;
                if ({obs_l[i], obs_r[i], obs_a[i]} !== {exp_l[i], exp_r[i], exp_a[i]}) begin
                    failures++;
                    $display("FAIL brake i%0d got L=%b R=%b A=%b want L=%b R=%b A=%b",
                             i, obs_l[i], obs_r[i], obs_a[i], exp_l[i], exp_r[i], exp_a[i]);
                end
            end
        end
        Brake = 1'b0;
        E = 1'b0;
    endtask
`endif

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(3) == 0) begin
                E = ($urandom_range(7) == 0);
                L = 1'($urandom_range(1));
                R = 1'($urandom_range(1));
`ifdef TURN_BRAKE_EN
                Brake = 1'($urandom_range(1));
`endif
            end
            clk_step();
            for (int i = 0; i < 2; i++) begin
                checks++;
                if ({obs_l[i], obs_r[i], obs_a[i]} !== {exp_l[i], exp_r[i], exp_a[i]}) begin
                    failures++;
                    $display("FAIL random k%0d i%0d got L=%b R=%b A=%b want L=%b R=%b A=%b",
                             k, i, obs_l[i], obs_r[i], obs_a[i], exp_l[i], exp_r[i], exp_a[i]);
                end
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        Rst_n    = 1'b0;
        E        = 1'b0;
        L        = 1'b0;
        R        = 1'b0;
`ifdef TURN_BRAKE_EN
        Brake    = 1'b0;
`endif
        test_reset();
        test_left_seq();
        test_right_slow();
        test_hazard();
        test_hazard_interrupt();
        test_reset_mid();
`ifdef TURN_BRAKE_EN
        test_brake();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
